// File: rtl/cmos_pixel_packer.sv
// ============================================================================
//  Module   : cmos_pixel_packer
//  Purpose  : DVP camera byte-to-pixel assembler. Gathers BYTES_PER_PIX bus
//             words per pixel while href is high, adds frame/line framing,
//             pixel/line coordinates, truncated-line detection and an
//             RGB565 -> RGB888 expansion of the low 16 pixel bits.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_pclk        sensor pixel clock
//    rst_n         synchronous active-low reset
//    i_vsync       frame sync, rising edge starts a frame
//    i_href        line valid / data enable
//    i_pdata       sensor data bus (IN_W)
//    o_pix         assembled pixel (IN_W*BYTES_PER_PIX)
//    o_rgb888      {R,G,B} expanded from o_pix[15:0]
//    o_valid       one-cycle strobe, pixel outputs valid
//    o_sof/o_sol   with o_valid: first pixel of frame / of line
//    o_eol         one-cycle pulse after a line ends
//    o_x/o_y       column / line of the presented pixel
//    o_line_err    line ended (or was aborted) with a partial pixel
//    o_frame_done  pulse when vsync rise closes a non-empty frame
// ============================================================================
`default_nettype none

module cmos_pixel_packer #(
  parameter int IN_W          = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int BYTE_ORDER    = 0,
  parameter int X_W           = 12,
  parameter int Y_W           = 12
) (
  input  logic                          i_pclk,
  input  logic                          rst_n,
  input  logic                          i_vsync,
  input  logic                          i_href,
  input  logic [IN_W-1:0]               i_pdata,
  output logic [IN_W*BYTES_PER_PIX-1:0] o_pix,
  output logic [23:0]                   o_rgb888,
  output logic                          o_valid,
  output logic                          o_sof,
  output logic                          o_sol,
  output logic                          o_eol,
  output logic [X_W-1:0]                o_x,
  output logic [Y_W-1:0]                o_y,
  output logic                          o_line_err,
  output logic                          o_frame_done
);

  localparam int                PIX_W    = IN_W * BYTES_PER_PIX;
  localparam int                CNT_W    = 2;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BYTES_PER_PIX - 1);

  typedef enum logic [1:0] {
    ST_WAIT_FRAME = 2'd0,
    ST_WAIT_LINE  = 2'd1,
    ST_IN_LINE    = 2'd2
  } state_e;

  state_e             state_q;
  logic               vsync_q;
  logic               href_q;
  logic               sof_pending_q;
  logic [CNT_W-1:0]   byte_cnt_q;
  logic [X_W-1:0]     x_q;
  logic [Y_W-1:0]     y_q;
  logic [PIX_W-1:0]   asm_q;

  logic [PIX_W-1:0]   asm_d;
  logic [23:0]        rgb_d;
  logic               vsync_rise_d;
  logic               take_byte_d;

  assign vsync_rise_d = i_vsync & ~vsync_q;

  // A line starts only on an href rising edge, so a line that was cut short
  // by vsync is not resumed half-way when href is still high afterwards.
  assign take_byte_d = ~vsync_rise_d &
                       (((state_q == ST_WAIT_LINE) & i_href & ~href_q) |
                        ((state_q == ST_IN_LINE) & i_href));

  // Each byte is written straight into its final slot of the pixel word.
  always_comb begin
    asm_d = asm_q;
    for (int k = 0; k < BYTES_PER_PIX; k++) begin
      if (byte_cnt_q == CNT_W'(k)) begin
        asm_d[((BYTE_ORDER == 0) ? (BYTES_PER_PIX - 1 - k) : k) * IN_W +: IN_W] = i_pdata;
      end
    end
  end

  generate
    if (PIX_W >= 16) begin : g_rgb
      // Replicate the top bits of each channel into the new low bits.
      assign rgb_d = {asm_d[15:11], asm_d[15:13],
                      asm_d[10:5],  asm_d[10:9],
                      asm_d[4:0],   asm_d[4:2]};
    end else begin : g_no_rgb
      assign rgb_d = '0;
    end
  endgenerate

  always_ff @(posedge i_pclk) begin
    if (!rst_n) begin
      state_q       <= ST_WAIT_FRAME;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      sof_pending_q <= 1'b0;
      byte_cnt_q    <= '0;
      x_q           <= '0;
      y_q           <= '0;
      asm_q         <= '0;
      o_pix         <= '0;
      o_rgb888      <= '0;
      o_valid       <= 1'b0;
      o_sof         <= 1'b0;
      o_sol         <= 1'b0;
      o_eol         <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_line_err    <= 1'b0;
      o_frame_done  <= 1'b0;
    end else begin
      vsync_q      <= i_vsync;
      href_q       <= i_href;
      o_valid      <= 1'b0;
      o_sof        <= 1'b0;
      o_sol        <= 1'b0;
      o_eol        <= 1'b0;
      o_line_err   <= 1'b0;
      o_frame_done <= 1'b0;

      if (vsync_rise_d) begin
        // New frame from any state; an open line is dropped without o_eol.
        o_frame_done  <= (y_q != '0) || (state_q == ST_IN_LINE);
        o_line_err    <= (state_q == ST_IN_LINE) && (byte_cnt_q != '0);
        state_q       <= ST_WAIT_LINE;
        sof_pending_q <= 1'b1;
        byte_cnt_q    <= '0;
        x_q           <= '0;
        y_q           <= '0;
      end else begin
        case (state_q)
          ST_WAIT_FRAME: begin
            state_q <= ST_WAIT_FRAME;
          end
          ST_WAIT_LINE: begin
            if (take_byte_d) begin
              state_q <= ST_IN_LINE;
            end
          end
          ST_IN_LINE: begin
            if (!i_href) begin
              state_q    <= ST_WAIT_LINE;
              o_eol      <= 1'b1;
              o_line_err <= (byte_cnt_q != '0);
              byte_cnt_q <= '0;
              x_q        <= '0;
              y_q        <= (y_q == '1) ? y_q : y_q + 1'b1;
            end
          end
          default: begin
            state_q <= ST_WAIT_FRAME;
          end
        endcase

        if (take_byte_d) begin
          if (byte_cnt_q == LAST_CNT) begin
            o_pix         <= asm_d;
            o_rgb888      <= rgb_d;
            o_valid       <= 1'b1;
            o_sof         <= sof_pending_q;
            o_sol         <= (x_q == '0);
            o_x           <= x_q;
            o_y           <= y_q;
            sof_pending_q <= 1'b0;
            x_q           <= (x_q == '1) ? x_q : x_q + 1'b1;
            byte_cnt_q    <= '0;
          end else begin
            asm_q      <= asm_d;
            byte_cnt_q <= byte_cnt_q + 1'b1;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cmos_pixel_packer.sv
`timescale 1ns/1ps
`default_nettype none

module tb_cmos_pixel_packer;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b0;
  logic       href  = 1'b0;
  logic [7:0] pdata = 8'h00;

  always #5 clk = ~clk;

  // Instance 0: 2 bytes, MSB first. Instance 1: 2 bytes, LSB first.
  // Instance 2: 3 bytes, MSB first. All share the same sensor stimulus.
  localparam int BPP [3] = '{2, 2, 3};
  localparam int ORD [3] = '{0, 1, 0};

  logic [15:0] a_pix, b_pix;
  logic [23:0] c_pix;
  logic [23:0] a_rgb, b_rgb, c_rgb;
  logic        a_v, a_sof, a_sol, a_eol, a_err, a_fd;
  logic        b_v, b_sof, b_sol, b_eol, b_err, b_fd;
  logic        c_v, c_sof, c_sol, c_eol, c_err, c_fd;
  logic [11:0] a_x, a_y, b_x, b_y, c_x, c_y;

  cmos_pixel_packer #(.IN_W(8), .BYTES_PER_PIX(2), .BYTE_ORDER(0), .X_W(12), .Y_W(12)) u_a (
    .i_pclk(clk), .rst_n(rst_n), .i_vsync(vsync), .i_href(href), .i_pdata(pdata),
    .o_pix(a_pix), .o_rgb888(a_rgb), .o_valid(a_v), .o_sof(a_sof), .o_sol(a_sol),
    .o_eol(a_eol), .o_x(a_x), .o_y(a_y), .o_line_err(a_err), .o_frame_done(a_fd));

  cmos_pixel_packer #(.IN_W(8), .BYTES_PER_PIX(2), .BYTE_ORDER(1), .X_W(12), .Y_W(12)) u_b (
    .i_pclk(clk), .rst_n(rst_n), .i_vsync(vsync), .i_href(href), .i_pdata(pdata),
    .o_pix(b_pix), .o_rgb888(b_rgb), .o_valid(b_v), .o_sof(b_sof), .o_sol(b_sol),
    .o_eol(b_eol), .o_x(b_x), .o_y(b_y), .o_line_err(b_err), .o_frame_done(b_fd));

  cmos_pixel_packer #(.IN_W(8), .BYTES_PER_PIX(3), .BYTE_ORDER(0), .X_W(12), .Y_W(12)) u_c (
    .i_pclk(clk), .rst_n(rst_n), .i_vsync(vsync), .i_href(href), .i_pdata(pdata),
    .o_pix(c_pix), .o_rgb888(c_rgb), .o_valid(c_v), .o_sof(c_sof), .o_sol(c_sol),
    .o_eol(c_eol), .o_x(c_x), .o_y(c_y), .o_line_err(c_err), .o_frame_done(c_fd));

  typedef struct {
    bit          v;
    bit          eol;
    bit          err;
    bit          fd;
    logic [31:0] pix;
    logic [23:0] rgb;
    int          x;
    int          y;
    bit          sof;
    bit          sol;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];
  ev_t q2[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference-model frame state.
  bit         frame_active = 1'b0;
  int         my           = 0;
  bit         sofp [3];
  logic [7:0] lb[$];

  function automatic ev_t blank();
    ev_t e;
    e.v = 0; e.eol = 0; e.err = 0; e.fd = 0;
    e.pix = 0; e.rgb = 0; e.x = 0; e.y = 0; e.sof = 0; e.sol = 0;
    return e;
  endfunction

  function automatic logic [23:0] rgb_of(input logic [31:0] pix);
    int p, r5, g6, b5, r8, g8, b8;
    p  = int'(pix) & 32'hFFFF;
    r5 = (p >> 11) & 31;
    g6 = (p >> 5) & 63;
    b5 = p & 31;
    r8 = (r5 << 3) | (r5 >> 2);
    g8 = (g6 << 2) | (g6 >> 4);
    b8 = (b5 << 3) | (b5 >> 2);
    return 24'((r8 << 16) | (g8 << 8) | b8);
  endfunction

  function automatic void push(input int i, input ev_t e);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic bit pop(input int i, output ev_t e);
    e = blank();
    case (i)
      0:       begin if (q0.size() == 0) return 0; e = q0.pop_front(); end
      1:       begin if (q1.size() == 0) return 0; e = q1.pop_front(); end
      default: begin if (q2.size() == 0) return 0; e = q2.pop_front(); end
    endcase
    return 1;
  endfunction

  // Expected responses for a line of n bytes held in lb.
  // kind: 0 = normal end, 1 = aborted by vsync, 2 = cut by reset.
  task automatic expect_line(input int n, input int kind);
    ev_t e;
    int  np;
    logic [31:0] pix;
    if (!frame_active) return;
    for (int i = 0; i < 3; i++) begin
      np = n / BPP[i];
      for (int p = 0; p < np; p++) begin
        pix = 0;
        for (int k = 0; k < BPP[i]; k++)
          pix = pix | (32'(lb[p*BPP[i]+k]) << (8 * ((ORD[i] != 0) ? k : (BPP[i] - 1 - k))));
        e = blank();
        e.v = 1; e.pix = pix; e.rgb = rgb_of(pix);
        e.x = p; e.y = my; e.sof = sofp[i]; e.sol = (p == 0);
        sofp[i] = 0;
        push(i, e);
      end
      if (kind == 0) begin
        e = blank(); e.eol = 1; e.err = (n % BPP[i]) != 0; push(i, e);
      end else if (kind == 1) begin
        e = blank(); e.fd = 1; e.err = (n % BPP[i]) != 0; push(i, e);
      end
    end
    if (kind == 0) my++;
    if (kind == 1) begin
      my = 0;
      for (int i = 0; i < 3; i++) sofp[i] = 1;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random(input int n);
    lb.delete();
    for (int j = 0; j < n; j++) lb.push_back(8'($urandom));
  endtask

  task automatic drive_bytes(input int n);
    for (int j = 0; j < n; j++) begin
      href  = 1'b1;
      pdata = lb[j];
      cyc();
    end
  endtask

  task automatic send_line(input int n, input int gap);
    expect_line(n, 0);
    drive_bytes(n);
    href  = 1'b0;
    pdata = 8'($urandom);
    repeat (gap) cyc();
  endtask

  task automatic vsync_pulse();
    ev_t e;
    if (frame_active && my > 0) begin
      for (int i = 0; i < 3; i++) begin
        e = blank(); e.fd = 1; push(i, e);
      end
    end
    frame_active = 1;
    my = 0;
    for (int i = 0; i < 3; i++) sofp[i] = 1;
    vsync = 1'b1; cyc(); cyc();
    vsync = 1'b0; cyc(); cyc();
  endtask

  task automatic abort_line(input int n);
    expect_line(n, 1);
    drive_bytes(n);
    vsync = 1'b1; pdata = 8'($urandom); cyc();
    href  = 1'b0; cyc();
    vsync = 1'b0; cyc(); cyc();
  endtask

  task automatic check_idle(input string name);
    n_checks++;
    if ({a_v, a_sof, a_sol, a_eol, a_err, a_fd} != 6'd0 || a_pix != 16'd0 ||
        a_rgb != 24'd0 || a_x != 12'd0 || a_y != 12'd0 ||
        {b_v, b_eol, b_fd} != 3'd0 || b_pix != 16'd0 ||
        {c_v, c_eol, c_fd} != 3'd0 || c_pix != 24'd0) begin
      n_fail++;
      $display("FAIL %s: outputs not cleared, got a_pix=%h a_rgb=%h a_v=%b a_x=%0d a_y=%0d b_pix=%h c_pix=%h, required all zero",
               name, a_pix, a_rgb, a_v, a_x, a_y, b_pix, c_pix);
    end
  endtask

  task automatic chk(input int i, input bit v, input bit eol, input bit err, input bit fd,
                     input logic [31:0] pix, input logic [23:0] rgb, input int x, input int y,
                     input bit sof, input bit sol);
    ev_t e;
    bit  bad;
    if (!(v || eol || err || fd)) return;
    n_checks++;
    if (!pop(i, e)) begin
      n_fail++;
      $display("FAIL unexpected_event inst%0d: got v=%b eol=%b err=%b fd=%b pix=%h, required no event",
               i, v, eol, err, fd, pix);
      return;
    end
    bad = (v != e.v) || (eol != e.eol) || (err != e.err) || (fd != e.fd);
    if (e.v && v)
      bad = bad || (pix != e.pix) || (rgb != e.rgb) || (x != e.x) || (y != e.y) ||
            (sof != e.sof) || (sol != e.sol);
    if (bad) begin
      n_fail++;
      $display("FAIL event inst%0d: got v=%b eol=%b err=%b fd=%b pix=%h rgb=%h x=%0d y=%0d sof=%b sol=%b; required v=%b eol=%b err=%b fd=%b pix=%h rgb=%h x=%0d y=%0d sof=%b sol=%b",
               i, v, eol, err, fd, pix, rgb, x, y, sof, sol,
               e.v, e.eol, e.err, e.fd, e.pix, e.rgb, e.x, e.y, e.sof, e.sol);
    end
  endtask

  // Monitor: consumes expected events whenever any DUT presents one.
  always @(negedge clk) begin
    chk(0, a_v, a_eol, a_err, a_fd, 32'(a_pix), a_rgb, int'(a_x), int'(a_y), a_sof, a_sol);
    chk(1, b_v, b_eol, b_err, b_fd, 32'(b_pix), b_rgb, int'(b_x), int'(b_y), b_sof, b_sol);
    chk(2, c_v, c_eol, c_err, c_fd, 32'(c_pix), c_rgb, int'(c_x), int'(c_y), c_sof, c_sol);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) sofp[i] = 0;
    rst_n = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("reset_state");
    cyc();

    // Line activity before any vsync must be ignored.
    fill_random(6);
    send_line(6, 3);

    vsync_pulse();
    lb = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF};
    send_line(8, 3);
    lb = '{8'h34, 8'h12};
    send_line(2, 2);
    lb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_line(6, 2);
    fill_random(5);
    send_line(5, 3);
    fill_random(1);
    send_line(1, 2);

    // Random frames, including an empty one.
    for (int f = 0; f < 4; f++) begin
      vsync_pulse();
      for (int l = 0; l < int'($urandom_range(0, 4)); l++) begin
        fill_random(int'($urandom_range(1, 14)));
        send_line(lb.size(), int'($urandom_range(2, 5)));
      end
    end

    // vsync arriving inside a line, with and without a partial pixel.
    fill_random(5);
    abort_line(5);
    fill_random(6);
    send_line(6, 2);
    fill_random(6);
    abort_line(6);
    fill_random(4);
    send_line(4, 2);
    vsync_pulse();

    // Reset held one cycle in the middle of a pixel.
    fill_random(5);
    expect_line(5, 2);
    drive_bytes(5);
    rst_n = 1'b0;
    href  = 1'b0;
    cyc();
    rst_n = 1'b1;
    frame_active = 0;
    my = 0;
    @(negedge clk);
    check_idle("reset_mid_line");
    cyc();
    fill_random(6);
    send_line(6, 3);
    vsync_pulse();
    fill_random(7);
    send_line(7, 3);
    fill_random(4);
    send_line(4, 3);
    vsync_pulse();

    repeat (6) cyc();
    n_checks++;
    if (q0.size() != 0) begin
      n_fail++;
      $display("FAIL drain inst0: %0d events outstanding, required 0", q0.size());
    end
    n_checks++;
    if (q1.size() != 0) begin
      n_fail++;
      $display("FAIL drain inst1: %0d events outstanding, required 0", q1.size());
    end
    n_checks++;
    if (q2.size() != 0) begin
      n_fail++;
      $display("FAIL drain inst2: %0d events outstanding, required 0", q2.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
